// File: rtl/arbiter_5_if.sv
// Request/grant bundle between five requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface arbiter_5_if;
   logic x0, x1, x2, x3, x4;
   logic y0, y1, y2, y3, y4;

   modport master (
      output x0, x1, x2, x3, x4,
      input  y0, y1, y2, y3, y4
   );

   modport slave (
      input  x0, x1, x2, x3, x4,
      output y0, y1, y2, y3, y4
   );
endinterface

// File: rtl/arbiter_5.sv
// Five-way round-robin mutual-exclusion arbiter; a grant is held while its request stays high.
// Latency 1 clock request->grant and release->handover; no backpressure, grants are registered one-hot.
module arbiter_5 (
   input  logic        clk,
   input  logic        rst_n,
   arbiter_5_if.slave  bus
);

   logic [4:0] req;
   logic [4:0] y_q, y_d;
   logic [2:0] p_q, p_d;
   logic       found;
   logic [3:0] idx;

   assign req = {bus.x4, bus.x3, bus.x2, bus.x1, bus.x0};

   always_comb begin
      y_d   = y_q;
      p_d   = p_q;
      found = 1'b0;
      idx   = 4'd0;
      // y_q is one-hot or zero, so any overlap means the holder is still requesting.
      if ((y_q & req) == 5'b00000) begin
         y_d = 5'b00000;
         for (int k = 1; k <= 5; k++) begin
            idx = {1'b0, p_q} + 4'(k);
            if (idx >= 4'd5) begin
               idx = idx - 4'd5;
            end
            if (!found && req[idx[2:0]]) begin
               found = 1'b1;
               y_d   = 5'b00001 << idx[2:0];
               p_d   = idx[2:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q <= 5'b00000;
         p_q <= 3'd4;
      end else begin
         y_q <= y_d;
         p_q <= p_d;
      end
   end

   assign bus.y0 = y_q[0];
   assign bus.y1 = y_q[1];
   assign bus.y2 = y_q[2];
   assign bus.y3 = y_q[3];
   assign bus.y4 = y_q[4];

endmodule

// File: tb/tb_arbiter_5.sv
// Directed bench for arbiter_5: reset, rotation, idle round-robin, exhaustive sweep, mid-tenure reset.
module tb_arbiter_5;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   arbiter_5_if bus ();

   arbiter_5 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] get_y();
      return {bus.y4, bus.y3, bus.y2, bus.y1, bus.y0};
   endfunction

   task automatic set_x(input logic [4:0] v);
      bus.x0 = v[0];
      bus.x1 = v[1];
      bus.x2 = v[2];
      bus.x3 = v[3];
      bus.x4 = v[4];
   endtask

   // Advance one edge and settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set_x(5'b00000);
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      do_reset();
      set_x(5'b00100);
      step();
      obs = get_y();
      vectors++;
      if (obs !== 5'b00100) begin
         miscompares++;
         $display("FAIL reset_setup: got %b want %b", obs, 5'b00100);
      end
      #2;
      rst_n = 1'b0;
      #1;
      obs = get_y();
      vectors++;
      if (obs !== 5'b00000) begin
         miscompares++;
         $display("FAIL reset_async: got %b want %b", obs, 5'b00000);
      end
      set_x(5'b00000);
      step();
      rst_n = 1'b1;
      step();
      obs = get_y();
      vectors++;
      if (obs !== 5'b00000) begin
         miscompares++;
         $display("FAIL reset_idle: got %b want %b", obs, 5'b00000);
      end
   endtask

   task automatic test_first_arb();
      logic [4:0] obs;
      set_x(5'b11111);
      step();
      obs = get_y();
      vectors++;
      if (obs !== 5'b00001) begin
         miscompares++;
         $display("FAIL first_grant: got %b want %b", obs, 5'b00001);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         obs = get_y();
         vectors++;
         if (obs !== 5'b00001) begin
            miscompares++;
            $display("FAIL hold_cycle%0d: got %b want %b", i, obs, 5'b00001);
         end
      end
   endtask

   task automatic test_rotation();
      logic [4:0] xs [6];
      logic [4:0] ys [6];
      logic [4:0] obs;
      xs = '{5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b10001, 5'b00001};
      ys = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b10000, 5'b00001};
      for (int i = 0; i < 6; i++) begin
         set_x(xs[i]);
         step();
         obs = get_y();
         vectors++;
         if (obs !== ys[i]) begin
            miscompares++;
            $display("FAIL rotation%0d x=%b: got %b want %b", i, xs[i], obs, ys[i]);
         end
      end
   endtask

   task automatic test_rr_idle();
      logic [4:0] xs [4];
      logic [4:0] ys [4];
      logic [4:0] obs;
      // Starts from Y=00001 (P=0); first vector moves to Y=00010 (P=1).
      xs = '{5'b00010, 5'b00000, 5'b00101, 5'b00001};
      ys = '{5'b00010, 5'b00000, 5'b00100, 5'b00001};
      for (int i = 0; i < 4; i++) begin
         set_x(xs[i]);
         step();
         obs = get_y();
         vectors++;
         if (obs !== ys[i]) begin
            miscompares++;
            $display("FAIL rr_idle%0d x=%b: got %b want %b", i, xs[i], obs, ys[i]);
         end
      end
   endtask

   task automatic test_sweep();
      logic [4:0] my;
      logic [2:0] mp;
      logic [4:0] obs;
      logic [4:0] xv;
      int         cand;
      do_reset();
      my = 5'b00000;
      mp = 3'd4;
      for (int pat = 0; pat < 32; pat++) begin
         xv = 5'(pat);
         for (int c = 0; c < 3; c++) begin
            set_x(xv);
            step();
            if (!((my != 5'b00000) && ((my & xv) == my))) begin
               my = 5'b00000;
               for (int k = 1; k <= 5; k++) begin
                  cand = (int'(mp) + k) % 5;
                  if (my == 5'b00000 && xv[cand]) begin
                     my = 5'b00001 << cand;
                     mp = 3'(cand);
                  end
               end
            end
            obs = get_y();
            vectors++;
            if ($countones(obs) > 1) begin
               miscompares++;
               $display("FAIL sweep_onehot x=%b: got %b want popcount<=1", xv, obs);
            end
            vectors++;
            if ((obs & ~xv) !== 5'b00000) begin
               miscompares++;
               $display("FAIL sweep_implies x=%b: got %b want subset of x", xv, obs);
            end
            vectors++;
            if (obs !== my) begin
               miscompares++;
               $display("FAIL sweep_model x=%b: got %b want %b", xv, obs, my);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [4:0] obs;
      do_reset();
      set_x(5'b01000);
      step();
      set_x(5'b11111);
      step();
      obs = get_y();
      vectors++;
      if (obs !== 5'b01000) begin
         miscompares++;
         $display("FAIL mid_setup: got %b want %b", obs, 5'b01000);
      end
      #2;
      rst_n = 1'b0;
      #1;
      obs = get_y();
      vectors++;
      if (obs !== 5'b00000) begin
         miscompares++;
         $display("FAIL mid_async: got %b want %b", obs, 5'b00000);
      end
      step();
      rst_n = 1'b1;
      step();
      obs = get_y();
      vectors++;
      if (obs !== 5'b00001) begin
         miscompares++;
         $display("FAIL mid_rearb: got %b want %b", obs, 5'b00001);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      set_x(5'b00000);
      test_reset();
      test_first_arb();
      test_rotation();
      test_rr_idle();
      test_sweep();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/arbiter_5.md
# arbiter_5

Five-requester mutual-exclusion arbiter with round-robin fairness and no preemption. It grants a shared resource to at most one of five requesters at a time. The grant is held for as long as the winning requester keeps its request asserted. The block sits between five independent request sources and a single shared resource. Grants are registered outputs that downstream logic uses directly as one-hot select/enable.

## Interface
- No parameters; requester count is fixed at 5.
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- X0..X4  input  1 each  request from requester 0..4; level-sensitive, synchronous to clk
- Y0..Y4  output  1 each  grant to requester 0..4; registered; one-hot or all-zero

## Operation
- State:
  - grant register Y[4:0], one-hot or zero.
  - last-winner pointer P[2:0], range 0..4.
- Reset (rst_n low, asynchronous): Y = 00000 immediately; P = 4, so requester 0 has first priority after reset.
- Each rising edge, with rst_n high, evaluate in this order:
  - Hold: if a grant Yk is active and Xk = 1, Y is unchanged and P is unchanged. Other requests are ignored; there is no preemption.
  - Release/handover: if Yk is active and Xk = 0, or if Y = 0, pick a new winner by round-robin search over the current X.
    - Search order: P+1, P+2, … modulo 5, ending at P itself.
    - The first index i with Xi = 1 wins: Y = one-hot(i) and P = i.
    - The releasing requester is not eligible in the same cycle because its X is 0.
  - No requests: if no Xi = 1, Y = 00000 and P is unchanged.
- Handover is direct. A release and a new grant can occur on the same edge, with no idle cycle in between.
- Invariants:
  - popcount(Y) ≤ 1 at all times, including during reset assertion and release.
  - Yi = 1 implies Xi was 1 at the most recent rising edge.
  - A requester that holds its request continuously is granted within 4 grant tenures of other requesters.
- Simultaneous events:
  - All five requests rising together from idle: the winner is P+1 mod 5.
  - Holder drops while others rise on the same edge: round-robin applies to the X values sampled at that edge.
- X values that are unknown (X/Z) are not supported. Requesters must drive 0 while idle; the bench holds X = 0 until reset is released.
- Wrap-around: with P = 4, the search order is 0,1,2,3,4. With P = 3, the search order is 4,0,1,2,3.

## Timing
- Grant latency: 1 clock. An X sampled at edge n produces Y valid after edge n.
- Release latency: 1 clock. Y deasserts after the first edge that samples Xk = 0.
- Reset is asynchronous on assertion: Y clears without a clock edge.
- Reset deassertion must be synchronous to clk (external synchronizer). The first update occurs on the first rising edge with rst_n high.
- Reset mid-tenure drops the grant at once and restores P = 4. The active requester must re-arbitrate.
- Outputs come directly from flops, with no combinational path from X to Y.
- Inputs must meet setup/hold to clk. The block has no internal synchronizers.

## Test plan
- Reset/idle: assert rst_n = 0 while Y = 00100 -> Y = 00000 immediately, without a clock edge. Release reset with X = 00000 -> Y stays 00000.
- First arbitration:
  - After reset, apply X = 11111 -> Y = 00001 after 1 edge.
  - Hold X = 11111 for 10 cycles -> Y stays 00001.
- Handover and rotation, starting from the 11111 state above:
  - X = 11110 -> Y = 00010.
  - Then X = 11100 -> Y = 00100.
  - Then X = 11000 -> Y = 01000.
  - Then X = 10000 -> Y = 10000.
  - Then X = 10001 -> Y unchanged at 10000.
  - Then X = 00001 -> Y = 00001 (wrap-around).
- Round-robin from idle:
  - From Y = 00010 (P = 1), apply X = 00000 -> Y = 00000.
  - Then X = 00101 -> Y = 00100 (search starts at 2).
  - Drop X2, keeping X = 00001 -> Y = 00001.
- Exhaustive sweep: apply all 32 X patterns in sequence, 3 cycles each -> after every edge, check:
  - popcount(Y) ≤ 1;
  - Yi implies Xi;
  - the winner matches a reference model of the round-robin rule above.
- Mid-tenure reset: with Y = 01000 and X = 11111, pulse rst_n low between edges -> Y = 00000 asynchronously. After release, with X = 11111 -> Y = 00001.
